pipe_bar: RTL and testbench

Parametrised pipeline barrier register: the general successor to the fixed IF/ID bar. It carries a PC, an instruction word and a sideband field between any two adjacent pipeline stages. It uses a valid/ready handshake, a 2-entry skid buffer, a global step enable, and a synchronous flush that inserts a NOP bubble. Every stage boundary in the processor (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it, with widths set per boundary.

---
 rtl/pipe_bar.sv | 118 +++++++++++
 tb/tb_pipe_bar.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bar.sv
// Pipeline barrier register with valid/ready handshake and 2-entry skid.
// Carries pc/instr/side between stages; flush and reset leave a NOP bubble.
module pipe_bar #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned SIDE_WIDTH  = 8,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR =
    INSTR_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [SIDE_WIDTH-1:0]  in_side,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [SIDE_WIDTH-1:0]  out_side,
  output logic [1:0]             occupancy
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [SIDE_WIDTH-1:0]  side;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;
  ent_t   in_ent, bubble;
  logic   accept, pop;

  assign bubble.pc    = '0;
  assign bubble.instr = NOP_INSTR;
  assign bubble.side  = '0;

  assign in_ent.pc    = in_pc;
  assign in_ent.instr = in_instr;
  assign in_ent.side  = in_side;

  // Handshake flags decode registered state only
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & step;
  assign pop       = out_valid & out_ready & step;

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign out_side  = main_q.side;
  assign occupancy = state;

  // Next-state and storage update; flush overrides everything
  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    skid_d    = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_d    = bubble;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_d    = in_ent;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_ent;
          end else if (accept) begin
            state_nxt = FULL;
            skid_d    = in_ent;
          end else if (pop) begin
            state_nxt = EMPTY;
            main_d    = bubble;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = ONE;
            main_d    = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_d    = bubble;
        end
      endcase
    end
  end

  // State and entry registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= bubble;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_bar.sv
// Bench for pipe_bar: vector table, directed corner sequences and a
// random stream checked against a queue-based reference.
module tb_pipe_bar;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [0:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [0:0]  out_side;
  logic [1:0]  occupancy;

  pipe_bar #(
    .PC_WIDTH(32),
    .INSTR_WIDTH(32),
    .SIDE_WIDTH(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .in_side(in_side),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_side(out_side),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [0:0]  side;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [1:0]  occ;
    logic        ov;
    logic        ir;
    logic [31:0] opc;
  } vec_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Compare every output against the queue model
  task automatic chk_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, " occupancy"}, 64'(occupancy), 64'(sz));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(sz > 0));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(sz < 2));
    chk({tag, " out_pc"}, 64'(out_pc),
        (sz > 0) ? 64'(q[0].pc) : 64'd0);
    chk({tag, " out_instr"}, 64'(out_instr),
        (sz > 0) ? 64'(q[0].instr) : 64'(NOP));
    chk({tag, " out_side"}, 64'(out_side),
        (sz > 0) ? 64'(q[0].side) : 64'd0);
  endtask

  // Advance one clock: update model from current inputs, then check
  task automatic tick(input string tag);
    int   sz;
    ent_t e;
    sz = q.size();
    e.pc = in_pc;
    e.instr = in_instr;
    e.side = in_side;
    if (flush) begin
      q.delete();
    end else if (step) begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic drive(input logic iv, input logic ordy,
                       input logic [31:0] pc);
    in_valid = iv;
    out_ready = ordy;
    in_pc = pc;
    in_instr = pc ^ 32'hA5A5_0000;
    in_side = pc[2];
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b1, 1'b1, 32'h1000, 2'd1, 1'b1, 1'b1, 32'h1000};
    vt[1]  = '{1'b1, 1'b1, 32'h1004, 2'd1, 1'b1, 1'b1, 32'h1004};
    vt[2]  = '{1'b1, 1'b1, 32'h1008, 2'd1, 1'b1, 1'b1, 32'h1008};
    vt[3]  = '{1'b0, 1'b1, 32'h0000, 2'd0, 1'b0, 1'b1, 32'h0000};
    vt[4]  = '{1'b1, 1'b0, 32'h2000, 2'd1, 1'b1, 1'b1, 32'h2000};
    vt[5]  = '{1'b1, 1'b0, 32'h2004, 2'd2, 1'b1, 1'b0, 32'h2000};
    vt[6]  = '{1'b1, 1'b0, 32'h2008, 2'd2, 1'b1, 1'b0, 32'h2000};
    vt[7]  = '{1'b1, 1'b0, 32'h2008, 2'd2, 1'b1, 1'b0, 32'h2000};
    vt[8]  = '{1'b1, 1'b1, 32'h2008, 2'd1, 1'b1, 1'b1, 32'h2004};
    vt[9]  = '{1'b1, 1'b1, 32'h2008, 2'd1, 1'b1, 1'b1, 32'h2008};
    vt[10] = '{1'b0, 1'b1, 32'h0000, 2'd0, 1'b0, 1'b1, 32'h0000};

    reset = 1'b1;
    step = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst occupancy", 64'(occupancy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_pc", 64'(out_pc), 64'd0);
    chk("rst out_instr", 64'(out_instr), 64'(NOP));
    chk("rst out_side", 64'(out_side), 64'd0);

    // Stream and backpressure vectors
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].pc);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d occ", i), 64'(occupancy), 64'(vt[i].occ));
      chk($sformatf("vec%0d ov", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("vec%0d ir", i), 64'(in_ready), 64'(vt[i].ir));
      chk($sformatf("vec%0d opc", i), 64'(out_pc), 64'(vt[i].opc));
    end

    // Flush while FULL with a live input
    drive(1'b1, 1'b0, 32'h2F00);
    tick("fl fill0");
    drive(1'b1, 1'b0, 32'h2F04);
    tick("fl fill1");
    chk("fl full occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    drive(1'b1, 1'b0, 32'h3000);
    tick("fl edge");
    flush = 1'b0;
    chk("fl occ", 64'(occupancy), 64'd0);
    chk("fl out_valid", 64'(out_valid), 64'd0);
    chk("fl out_instr", 64'(out_instr), 64'(NOP));
    chk("fl out_pc", 64'(out_pc), 64'd0);
    drive(1'b0, 1'b1, 32'h0);
    repeat (3) tick("fl after");
    chk("fl no 3000", 64'(out_valid), 64'd0);

    // Step held low freezes everything
    drive(1'b1, 1'b0, 32'h4000);
    tick("st load");
    step = 1'b0;
    drive(1'b1, 1'b1, 32'h4004);
    for (int i = 0; i < 4; i++) begin
      tick("st hold");
      chk($sformatf("st%0d occ", i), 64'(occupancy), 64'd1);
      chk($sformatf("st%0d opc", i), 64'(out_pc), 64'h4000);
    end
    step = 1'b1;
    tick("st resume");
    chk("st resume opc", 64'(out_pc), 64'h4004);
    drive(1'b0, 1'b1, 32'h0);
    tick("st drain");

    // Asynchronous reset mid-cycle while FULL
    drive(1'b1, 1'b0, 32'h5000);
    tick("ar fill0");
    drive(1'b1, 1'b0, 32'h5004);
    tick("ar fill1");
    chk("ar full occ", 64'(occupancy), 64'd2);
    drive(1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("ar occ", 64'(occupancy), 64'd0);
    chk("ar out_valid", 64'(out_valid), 64'd0);
    chk("ar in_ready", 64'(in_ready), 64'd1);
    chk("ar out_pc", 64'(out_pc), 64'd0);
    chk("ar out_instr", 64'(out_instr), 64'(NOP));
    #2;
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h6000);
    tick("ar first");
    chk("ar first opc", 64'(out_pc), 64'h6000);
    chk("ar first ov", 64'(out_valid), 64'd1);

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_pc = $urandom;
      in_instr = $urandom;
      in_side = 1'($urandom);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
